// File: rtl/dma_buf_sequencer.sv
// Host DMA launch sequencer: waits for FIFO fill, requests a transfer, advances the
// host ring-buffer index on completion and raises the per-buffer interrupt.
module dma_buf_sequencer #(
    parameter int unsigned N_BUF     = 16,
    parameter int unsigned BUF_IDX_W = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 trn_clk,
    input  logic                 trn_reset,
    input  logic                 acq_en,
    input  logic [24:0]          dma_size,
    input  logic [CNT_W-1:0]     dma_flag_words,
    input  logic [CNT_W-1:0]     fifo_rd_count,
    output logic                 dma_req,
    output logic [29:0]          dma_len_dw,
    input  logic                 dma_req_ack,
    input  logic                 dma_done,
    input  logic                 dma_error,
    output logic [BUF_IDX_W-1:0] dma_curr_buf,
    output logic                 irq_req,
    input  logic                 irq_ack,
    output logic [31:0]          buf_count,
    output logic [3:0]           status_flags
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_DATA, ST_REQ, ST_XFER, ST_ADVANCE, ST_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic                 dma_req_q, dma_req_d;
    logic [29:0]          dma_len_dw_q, dma_len_dw_d;
    logic [BUF_IDX_W-1:0] curr_buf_q, curr_buf_d;
    logic                 irq_req_q, irq_req_d;
    logic [31:0]          buf_count_q, buf_count_d;
    logic                 err_q, err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 data_ready_q, data_ready_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        dma_len_dw_d = dma_len_dw_q;
        curr_buf_d   = curr_buf_q;
        irq_req_d    = irq_req_q;
        buf_count_d  = buf_count_q;
        err_d        = err_q;
        overrun_d    = overrun_q;

        if (irq_ack) begin
            irq_req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (acq_en) begin
                    curr_buf_d  = '0;
                    buf_count_d = '0;
                    overrun_d   = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!acq_en) begin
                    state_d = ST_IDLE;
                end else if (data_ready_q && (dma_size != 25'd0)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dma_error) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else if (dma_req_ack) begin
                    state_d = ST_XFER;
                end else if (!acq_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (dma_error) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else if (dma_done) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                curr_buf_d  = (curr_buf_q == BUF_IDX_W'(N_BUF - 1)) ? '0
                                                                   : curr_buf_q + BUF_IDX_W'(1);
                buf_count_d = buf_count_q + 32'd1;
                // An ack landing in this same cycle services the previous buffer in time
                if (irq_req_q && !irq_ack) begin
                    overrun_d = 1'b1;
                end
                irq_req_d = 1'b1;
                state_d   = acq_en ? ST_WAIT_DATA : ST_IDLE;
            end
            ST_ERROR: begin
                if (!acq_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Length is frozen at REQ entry so later size writes cannot disturb the transfer
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            dma_len_dw_d = {dma_size, 5'b0};
        end

        dma_req_d    = (state_d == ST_REQ);
        busy_d       = (state_d == ST_XFER);
        data_ready_d = (state_d == ST_WAIT_DATA) && (fifo_rd_count >= dma_flag_words);
    end

    // State and output registers
    always_ff @(posedge trn_clk) begin
        if (trn_reset) begin
            state_q      <= ST_IDLE;
            dma_req_q    <= 1'b0;
            dma_len_dw_q <= '0;
            curr_buf_q   <= '0;
            irq_req_q    <= 1'b0;
            buf_count_q  <= '0;
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dma_req_q    <= dma_req_d;
            dma_len_dw_q <= dma_len_dw_d;
            curr_buf_q   <= curr_buf_d;
            irq_req_q    <= irq_req_d;
            buf_count_q  <= buf_count_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign dma_req      = dma_req_q;
    assign dma_len_dw   = dma_len_dw_q;
    assign dma_curr_buf = curr_buf_q;
    assign irq_req      = irq_req_q;
    assign buf_count    = buf_count_q;
    assign status_flags = {err_q, overrun_q, busy_q, data_ready_q};

endmodule

// File: tb/tb_dma_buf_sequencer.sv
// Directed bench for dma_buf_sequencer: latency, ring wrap, overrun, stop, error and reset cases.
module tb_dma_buf_sequencer;

    logic        trn_clk = 1'b0;
    logic        trn_reset;
    logic        acq_en;
    logic [24:0] dma_size;
    logic [15:0] dma_flag_words;
    logic [15:0] fifo_rd_count;
    logic        dma_req;
    logic [29:0] dma_len_dw;
    logic        dma_req_ack;
    logic        dma_done;
    logic        dma_error;
    logic [3:0]  dma_curr_buf;
    logic        irq_req;
    logic        irq_ack;
    logic [31:0] buf_count;
    logic [3:0]  status_flags;

    int n_tests = 0;
    int n_fail  = 0;

    dma_buf_sequencer #(.N_BUF(16), .BUF_IDX_W(4), .CNT_W(16)) dut (
        .trn_clk        (trn_clk),
        .trn_reset      (trn_reset),
        .acq_en         (acq_en),
        .dma_size       (dma_size),
        .dma_flag_words (dma_flag_words),
        .fifo_rd_count  (fifo_rd_count),
        .dma_req        (dma_req),
        .dma_len_dw     (dma_len_dw),
        .dma_req_ack    (dma_req_ack),
        .dma_done       (dma_done),
        .dma_error      (dma_error),
        .dma_curr_buf   (dma_curr_buf),
        .irq_req        (irq_req),
        .irq_ack        (irq_ack),
        .buf_count      (buf_count),
        .status_flags   (status_flags)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for dma_req; timeout shows up as a failed comparison
    task automatic wait_req(input int exp_buf);
        int k = 0;
        while (dma_req !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        chk("req_rise", 32'(dma_req), 32'd1);
        chk("req_buf_idx", 32'(dma_curr_buf), 32'(exp_buf));
    endtask

    // One full transfer; irq_mode 0: no ack, 1: ack after ADVANCE, 2: ack in ADVANCE cycle
    task automatic run_xfer(input int irq_mode, input int exp_buf);
        wait_req(exp_buf);
        dma_req_ack = 1'b1;
        tick(1);
        dma_req_ack = 1'b0;
        dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        if (irq_mode == 2) irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        if (irq_mode == 1) begin
            irq_ack = 1'b1;
            tick(1);
            irq_ack = 1'b0;
        end
    endtask

    initial begin
        int nreq;
        trn_reset = 1'b1; acq_en = 1'b0; dma_size = '0; dma_flag_words = '0;
        fifo_rd_count = '0; dma_req_ack = 1'b0; dma_done = 1'b0; dma_error = 1'b0;
        irq_ack = 1'b0;

        // Reset state
        tick(2);
        chk("rst_req", 32'(dma_req), 32'd0);
        chk("rst_buf", 32'(dma_curr_buf), 32'd0);
        chk("rst_irq", 32'(irq_req), 32'd0);
        chk("rst_count", buf_count, 32'd0);
        chk("rst_status", 32'(status_flags), 32'd0);
        trn_reset = 1'b0;

        // Basic: 4 KiB transfer, threshold crossing latency
        dma_size = 25'd32; dma_flag_words = 16'd1024; fifo_rd_count = 16'd1000; acq_en = 1'b1;
        tick(1);
        tick(3);
        chk("below_thresh_no_req", 32'(dma_req), 32'd0);
        fifo_rd_count = 16'd1024;
        tick(1);
        chk("lat1_req", 32'(dma_req), 32'd0);
        chk("lat1_ready", 32'(status_flags), 32'h1);
        tick(1);
        chk("lat2_req", 32'(dma_req), 32'd1);
        chk("len_dw", 32'(dma_len_dw), 32'd1024);
        dma_size = 25'd64;
        tick(2);
        chk("req_hold", 32'(dma_req), 32'd1);
        chk("len_frozen", 32'(dma_len_dw), 32'd1024);
        dma_req_ack = 1'b1;
        tick(1);
        dma_req_ack = 1'b0;
        chk("ack_drop_req", 32'(dma_req), 32'd0);
        chk("xfer_busy", 32'(status_flags), 32'h2);
        tick(3);
        dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        chk("adv_buf_unchanged", 32'(dma_curr_buf), 32'd0);
        chk("adv_irq_not_yet", 32'(irq_req), 32'd0);
        tick(1);
        chk("basic_buf", 32'(dma_curr_buf), 32'd1);
        chk("basic_count", buf_count, 32'd1);
        chk("basic_irq", 32'(irq_req), 32'd1);
        dma_size = 25'd32;

        // Wrap: restart, 17 transfers with immediate irq ack
        acq_en = 1'b0; irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("irq_ack_clear", 32'(irq_req), 32'd0);
        tick(1);
        acq_en = 1'b1;
        tick(1);
        chk("start_buf", 32'(dma_curr_buf), 32'd0);
        chk("start_count", buf_count, 32'd0);
        for (int i = 0; i < 17; i++) run_xfer(1, i % 16);
        chk("wrap_buf", 32'(dma_curr_buf), 32'd1);
        chk("wrap_count", buf_count, 32'd17);
        chk("wrap_no_overrun", 32'(status_flags[2]), 32'd0);

        // Overrun, and ack coinciding with ADVANCE
        acq_en = 1'b0;
        tick(2);
        acq_en = 1'b1;
        tick(1);
        run_xfer(0, 0);
        chk("ovr_first_irq", 32'(irq_req), 32'd1);
        chk("ovr_first_clear", 32'(status_flags[2]), 32'd0);
        run_xfer(2, 1);
        chk("ack_adv_irq_set", 32'(irq_req), 32'd1);
        chk("ack_adv_no_ovr", 32'(status_flags[2]), 32'd0);
        run_xfer(0, 2);
        chk("ovr_set", 32'(status_flags[2]), 32'd1);

        // Stop during XFER: transfer completes, no further requests
        acq_en = 1'b0; irq_ack = 1'b1;
        tick(2);
        irq_ack = 1'b0; acq_en = 1'b1;
        tick(1);
        wait_req(0);
        dma_req_ack = 1'b1;
        tick(1);
        dma_req_ack = 1'b0; acq_en = 1'b0;
        tick(3);
        chk("stop_xfer_busy", 32'(status_flags), 32'h2);
        dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        tick(1);
        chk("stop_buf", 32'(dma_curr_buf), 32'd1);
        chk("stop_count", buf_count, 32'd1);
        tick(10);
        chk("stop_no_req", 32'(dma_req), 32'd0);
        chk("stop_status", 32'(status_flags), 32'h0);

        // Stop during REQ: request drops next cycle
        acq_en = 1'b1;
        tick(1);
        wait_req(0);
        acq_en = 1'b0;
        tick(1);
        chk("req_abort", 32'(dma_req), 32'd0);
        tick(5);
        chk("req_abort_stays", 32'(dma_req), 32'd0);

        // Zero size with full FIFO never requests
        dma_size = 25'd0; acq_en = 1'b1; nreq = 0;
        repeat (1000) begin
            tick(1);
            if (dma_req) nreq++;
        end
        chk("zero_size_no_req", 32'(nreq), 32'd0);
        chk("zero_size_ready", 32'(status_flags), 32'h1);

        // Error in XFER
        acq_en = 1'b0; irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0; dma_size = 25'd32; acq_en = 1'b1;
        tick(1);
        run_xfer(0, 0);
        wait_req(1);
        dma_req_ack = 1'b1;
        tick(1);
        dma_req_ack = 1'b0; dma_error = 1'b1;
        tick(1);
        dma_error = 1'b0;
        chk("err_req", 32'(dma_req), 32'd0);
        chk("err_status", 32'(status_flags), 32'h8);
        nreq = 0;
        repeat (20) begin
            tick(1);
            if (dma_req) nreq++;
        end
        chk("err_no_req", 32'(nreq), 32'd0);
        acq_en = 1'b0;
        tick(1);
        chk("err_sticky_idle", 32'(status_flags), 32'h8);
        acq_en = 1'b1;
        tick(1);
        chk("err_cleared", 32'(status_flags), 32'h1);
        chk("err_restart_buf", 32'(dma_curr_buf), 32'd0);

        // Reset during XFER with irq pending
        wait_req(0);
        dma_req_ack = 1'b1;
        tick(1);
        dma_req_ack = 1'b0;
        chk("pre_rst_irq", 32'(irq_req), 32'd1);
        trn_reset = 1'b1;
        tick(1);
        chk("xrst_req", 32'(dma_req), 32'd0);
        chk("xrst_buf", 32'(dma_curr_buf), 32'd0);
        chk("xrst_irq", 32'(irq_req), 32'd0);
        chk("xrst_count", buf_count, 32'd0);
        chk("xrst_status", 32'(status_flags), 32'd0);
        chk("xrst_len", 32'(dma_len_dw), 32'd0);
        acq_en = 1'b0; trn_reset = 1'b0; dma_done = 1'b1;
        tick(1);
        dma_done = 1'b0;
        tick(2);
        chk("post_rst_done_buf", 32'(dma_curr_buf), 32'd0);
        chk("post_rst_done_count", buf_count, 32'd0);
        chk("post_rst_done_irq", 32'(irq_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_buf_sequencer.md
Name: dma_buf_sequencer

Overview:
Downstream consumer of the BAR1 register block. Takes its DMA configuration outputs (command, dma_size, dma_flag_words) and the acquisition FIFO fill level, and decides when to launch each host DMA transfer. Owns and advances the current host-buffer index that BAR1 uses to select dma_host_addr, and raises the per-buffer interrupt request. Sits between BAR1 registers, the ADC FIFO and the PCIe TX DMA engine.

Parameters:
N_BUF, 16, number of host ring buffers; index wraps at N_BUF-1.
BUF_IDX_W, 4, width of dma_curr_buf; must satisfy 2**BUF_IDX_W >= N_BUF.
CNT_W, 16, width of FIFO word count and threshold.

Ports:
trn_clk  in  1  sole clock, PCIe transaction clock
trn_reset  in  1  synchronous reset, active-high
acq_en  in  1  acquisition enable (command bit from BAR1), level
dma_size  in  25  bytes per DMA, bits [31:7] (128-byte granules)
dma_flag_words  in  CNT_W  FIFO 32-bit-word threshold to start a DMA
fifo_rd_count  in  CNT_W  words currently in acquisition FIFO
dma_req  out  1  request to TX DMA engine, level until acked
dma_len_dw  out  30  transfer length in DWORDs = {dma_size,5'b0}
dma_req_ack  in  1  one-cycle accept from DMA engine
dma_done  in  1  one-cycle pulse: last TLP of current buffer sent
dma_error  in  1  one-cycle pulse: DMA engine fault
dma_curr_buf  out  BUF_IDX_W  buffer index driving BAR1 address mux
irq_req  out  1  interrupt request, level
irq_ack  in  1  one-cycle interrupt service acknowledge
buf_count  out  32  completed buffers since acquisition start
status_flags  out  4  {err, overrun, busy, data_ready}

Behaviour:
- Reset (trn_reset=1 at posedge): state=IDLE; dma_req=0, dma_curr_buf=0, irq_req=0, buf_count=0, status_flags=0. Reset mid-transfer abandons the transfer with no completion side effects.
- FSM states: IDLE, WAIT_DATA, REQ, XFER, ADVANCE, ERROR.
- IDLE: on acq_en=1: dma_curr_buf<=0, buf_count<=0, overrun<=0, go WAIT_DATA.
- WAIT_DATA: data_ready = (fifo_rd_count >= dma_flag_words), unsigned compare, registered. If data_ready and dma_size!=0 -> REQ next cycle. dma_size==0 never requests. Threshold 0 means immediate. acq_en=0 -> IDLE.
- REQ: dma_req=1 and dma_len_dw stable until the cycle dma_req_ack=1 (inclusive), then dma_req=0 and go XFER. acq_en=0 before ack -> drop dma_req, go IDLE. dma_len_dw is captured on REQ entry; later dma_size writes do not affect the transfer in flight.
- XFER: busy=1; wait for dma_done. acq_en falling does not abort; the transfer completes. dma_done -> ADVANCE.
- ADVANCE (one cycle): dma_curr_buf <= (dma_curr_buf==N_BUF-1) ? 0 : +1; buf_count+1 (wraps at 2^32). If irq_req already 1, set overrun (sticky). irq_req<=1. Next state: WAIT_DATA if acq_en, else IDLE.
- dma_curr_buf changes only in ADVANCE, IDLE entry from reset, or acquisition start. It is stable throughout REQ and XFER.
- irq_req: cleared by irq_ack. If irq_ack and ADVANCE occur in the same cycle, the set wins (irq_req=1) and no overrun is flagged.
- dma_error in REQ or XFER: dma_req<=0, err<=1 (sticky), go ERROR. Ignored in other states.
- ERROR: no requests issued. Leave to IDLE only when acq_en=0; err clears at the next acquisition start.
- dma_done or dma_req_ack outside XFER or REQ respectively: ignored.
- Latency: data_ready condition to dma_req=1 is 2 cycles (compare register plus state transition). dma_done to irq_req=1 and dma_curr_buf update is 2 cycles.

Test Plan:
- Basic: dma_size=25'd32 (4 KiB), dma_flag_words=1024; ramp fifo_rd_count 1000->1024 -> dma_req rises 2 cycles later with dma_len_dw=1024; ack, then done -> dma_curr_buf=1, buf_count=1, irq_req=1.
- Wrap: 17 back-to-back transfers with immediate irq_ack -> dma_curr_buf sequence 0..15,0,1; buf_count=17; overrun=0.
- Overrun: no irq_ack over 2 completions -> overrun=1 after the second ADVANCE; irq_ack and dma_done 1 cycle apart -> irq_req stays 1.
- Stop mid-transfer: acq_en=0 during XFER -> no abort; on dma_done curr_buf increments, FSM goes IDLE, dma_req never reasserts. acq_en=0 during REQ -> dma_req drops next cycle.
- Error/zero size: dma_size=0 with a full FIFO -> no dma_req for 1000 cycles. dma_error in XFER -> err=1, no further dma_req until acq_en toggles 0->1, which clears err and resets dma_curr_buf to 0.
- Reset: trn_reset in XFER with irq_req=1 -> all outputs 0 on the next cycle; a subsequent dma_done pulse has no effect.
